// File: rtl/pp_align_normalizer.sv
// pp_align_normalizer: aligns nine signed partial products to exp_max, sums them and renormalizes to {sign, exp[3:0], mant[2:0]}.
// Ports: clk/rst (sync, active-high); in_valid/in_ready with signed_pp_in, exp_in (nine 5-bit lanes, lane 0 in the MSBs),
// exp_max_in, exp_bias_in; out_valid/out_ready with out_data, out_sat (exponent > 15) and out_flush (exponent < 0).
// Three stages (align, sum, normalize) share one stall: en = !out_valid || out_ready.
// Define SD4_ROUND_NEAREST_EN to round the mantissa to nearest-even instead of truncating it.
module pp_align_normalizer #(
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [44:0] signed_pp_in,
  input  logic [44:0] exp_in,
  input  logic [4:0]  exp_max_in,
  input  logic [4:0]  exp_bias_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sat,
  output logic        out_flush
);
  localparam int SUM_W = GUARD + 9;
  localparam int MAG_W = GUARD + 4;
  localparam int P_W = $clog2(SUM_W);
`ifdef SD4_ROUND_NEAREST_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic en, va, vb, neg, c, sat, flush;
  logic [4:0] pp [9];
  logic [4:0] sh [9];
  logic [MAG_W-1:0] mag [9];
  logic signed [SUM_W-1:0] ta_d [9];
  logic signed [SUM_W-1:0] ta [9];
  logic signed [SUM_W-1:0] sum_d, sb;
  logic [4:0] ea, ba, eb, bb;
  logic [SUM_W-1:0] m, norm;
  logic [P_W-1:0] p;
  logic [2:0] mant, mr;
  logic signed [7:0] e, er;
  logic [7:0] od;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      pp[k] = signed_pp_in[44-5*k -: 5];
      sh[k] = exp_max_in - exp_in[44-5*k -: 5];
      mag[k] = sh[k] >= 5'(MAG_W) ? '0 : {pp[k][3:0], {GUARD{1'b0}}} >> sh[k];
      ta_d[k] = pp[k] == 5'd0 ? '0 : pp[k][4] ? -SUM_W'(mag[k]) : SUM_W'(mag[k]);
    end
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) sum_d = sum_d + ta[k];
  end
  // norm puts the leading one of |sum| in its MSB, so the mantissa and the
  // round bits sit at fixed positions; a zero sum leaves the MSB clear.
  always_comb begin
    neg = sb[SUM_W-1];
    m = neg ? -sb : sb;
    p = '0;
    for (int i = 0; i < SUM_W; i++) if (m[i]) p = P_W'(i);
    norm = m << (P_W'(SUM_W - 1) - p);
    mant = norm[SUM_W-2 -: 3];
    e = 8'(eb) + 8'(p) - 8'(GUARD + 3) - 8'(bb);
    {c, mr} = {1'b0, mant} + 4'(RND && norm[SUM_W-5] && (|norm[SUM_W-6:0] || mant[0]));
    er = e + 8'(c);
    sat = norm[SUM_W-1] && er > 8'sd15;
    flush = norm[SUM_W-1] && er < 8'sd0;
    od = sat ? {neg, 7'h7F} : (!norm[SUM_W-1] || flush) ? 8'h00 : {neg, er[3:0], mr};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      va <= 1'b0;
      vb <= 1'b0;
      out_valid <= 1'b0;
      ta <= '{default: '0};
      ea <= '0;
      ba <= '0;
      eb <= '0;
      bb <= '0;
      sb <= '0;
      out_data <= 8'h00;
      out_sat <= 1'b0;
      out_flush <= 1'b0;
    end else if (en) begin
      va <= in_valid;
      ta <= ta_d;
      ea <= exp_max_in;
      ba <= exp_bias_in;
      vb <= va;
      sb <= sum_d;
      eb <= ea;
      bb <= ba;
      out_valid <= vb;
      out_data <= od;
      out_sat <= sat;
      out_flush <= flush;
    end
  end
endmodule

// File: tb/tb_pp_align_normalizer.sv
// tb_pp_align_normalizer: scoreboard bench for pp_align_normalizer; results are packed as {sat, flush, data}.
module tb_pp_align_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_sat, out_flush;
  logic [44:0] signed_pp_in = '0;
  logic [44:0] exp_in = '0;
  logic [4:0] exp_max_in = '0;
  logic [4:0] exp_bias_in = '0;
  logic [7:0] out_data;
  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  bit rnd_bp = 1'b0;
  logic [9:0] q [$];
  always #5 clk = ~clk;
  pp_align_normalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_pp_in(signed_pp_in), .exp_in(exp_in), .exp_max_in(exp_max_in),
    .exp_bias_in(exp_bias_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_flush(out_flush)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [44:0] ln(input int k, input logic [4:0] v);
    return {40'b0, v} << (40 - 5 * k);
  endfunction
  function automatic logic [9:0] model(input logic [44:0] pp, input logic [44:0] ex, input logic [4:0] emax, input logic [4:0] bias);
    int s, m, p, e, mant, sh;
    logic [4:0] t;
`ifdef SD4_ROUND_NEAREST_EN
    int rem, half;
`endif
    s = 0;
    for (int k = 0; k < 9; k++) begin
      t = pp[44-5*k -: 5];
      sh = int'(emax) - int'(ex[44-5*k -: 5]);
      if (t != 0 && sh < 8) begin
        m = (int'(t[3:0]) * 16) >> sh;
        s += t[4] ? -m : m;
      end
    end
    if (s == 0) return 10'h000;
    m = s < 0 ? -s : s;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = int'(emax) + p - 7 - int'(bias);
    mant = p >= 3 ? (m >> (p - 3)) & 7 : (m << (3 - p)) & 7;
`ifdef SD4_ROUND_NEAREST_EN
    if (p >= 4) begin
      rem = m & ((1 << (p - 3)) - 1);
      half = 1 << (p - 4);
      if (rem > half || (rem == half && (mant & 1) == 1)) mant++;
    end
    if (mant == 8) begin
      mant = 0;
      e++;
    end
`endif
    if (e > 15) return {2'b10, s < 0, 7'h7F};
    if (e < 0) return 10'h100;
    return {2'b00, s < 0, 4'(e), 3'(mant)};
  endfunction
  task automatic send(input logic [44:0] pp, input logic [44:0] ex, input logic [4:0] emax, input logic [4:0] bias);
    int w = 0;
    signed_pp_in = pp;
    exp_in = ex;
    exp_max_in = emax;
    exp_bias_in = bias;
    in_valid = 1'b1;
    if (rnd_bp) out_ready = $urandom_range(0, 3) != 0;
    #1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
      if (rnd_bp) out_ready = $urandom_range(0, 3) != 0;
      #1;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else q.push_back(model(pp, ex, emax, bias));
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic rand_send();
    logic [44:0] pp = '0;
    logic [44:0] ex = '0;
    logic [4:0] emax = 5'($urandom_range(0, 20));
    for (int k = 0; k < 9; k++) begin
      pp[44-5*k -: 5] = $urandom_range(0, 3) == 0 ? 5'd0 : {1'($urandom), 1'b1, 3'($urandom)};
      ex[44-5*k -: 5] = emax - 5'($urandom_range(0, emax > 10 ? 10 : int'(emax)));
    end
    send(pp, ex, emax, 5'($urandom_range(0, 15)));
  endtask
  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask
  task automatic latency();
    chk("lat_c1", out_valid, 0);
    @(negedge clk);
    chk("lat_c2", out_valid, 0);
    @(negedge clk);
    chk("lat_c3", out_valid, 1);
  endtask
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) chk("unexpected_out", out_valid, 0);
      else chk($sformatf("result#%0d", n_out), {out_sat, out_flush, out_data}, q.pop_front());
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] hold;
    int base;
    repeat (2) @(negedge clk);
    chk("rst_out", {out_valid, out_sat, out_flush, out_data}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    send(ln(0, 5'b01010), ln(0, 5'd5), 5'd5, 5'd0);
    latency();
    send(ln(0, 5'b01010) | ln(1, 5'b11010), ln(0, 5'd5) | ln(1, 5'd5), 5'd5, 5'd0);
    send(ln(0, 5'b01000) | ln(1, 5'b01000), ln(0, 5'd3) | ln(1, 5'd3), 5'd3, 5'd0);
    send(ln(0, 5'b01111), ln(0, 5'd20), 5'd20, 5'd10);
    send(ln(0, 5'b01111), ln(0, 5'd20), 5'd20, 5'd0);
    send(ln(0, 5'b11111), ln(0, 5'd20), 5'd20, 5'd0);
    send(ln(0, 5'b01000), ln(0, 5'd2), 5'd2, 5'd5);
    send(ln(0, 5'b01111) | ln(1, 5'b01000), ln(0, 5'd4), 5'd4, 5'd0);
    drain();
    base = n_out;
    out_ready = 1'b0;
    send(ln(2, 5'b01001), ln(2, 5'd9), 5'd9, 5'd2);
    send(ln(3, 5'b11011), ln(3, 5'd7), 5'd7, 5'd1);
    chk("bp_ov_early", out_valid, 0);
    send(ln(4, 5'b01101), ln(4, 5'd12), 5'd12, 5'd3);
    chk("bp_ov_rise", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    hold = {out_sat, out_flush, out_data};
    repeat (3) @(negedge clk);
    chk("bp_hold", {out_sat, out_flush, out_data}, hold);
    chk("bp_ov_hold", out_valid, 1);
    out_ready = 1'b1;
    send(ln(5, 5'b11100), ln(5, 5'd6), 5'd6, 5'd0);
    send(ln(8, 5'b01110), ln(8, 5'd15), 5'd15, 5'd4);
    drain();
    chk("bp_count", n_out - base, 5);
    base = n_out;
    send(ln(0, 5'b01100), ln(0, 5'd8), 5'd8, 5'd1);
    send(ln(1, 5'b10101), ln(1, 5'd8), 5'd8, 5'd1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ov", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_stale", out_valid, 0);
    end
    chk("rst_no_out", n_out - base, 0);
    send(ln(6, 5'b01011), ln(6, 5'd10), 5'd10, 5'd3);
    latency();
    drain();
    rnd_bp = 1'b1;
    repeat (40) rand_send();
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pp_align_normalizer.md
Name: pp_align_normalizer

Overview:
- Second half of the SD4 MAC datapath. Consumes the registered stage-1 bundle: nine signed partial products, nine lane exponents, the max exponent and the exponent bias.
- Aligns each lane to exp_max, converts it to two's complement and sums the nine terms.
- Normalizes the sum back into the 8-bit image format {sign, exp[3:0], mant[2:0]}, so the reverse direction of the partial-product generator.
- 3-stage valid/ready pipeline with global stall.

Parameters:
- GUARD, 4, fraction bits appended below the 4-bit significand before right-shift alignment.
- SUM_W, GUARD+9, adder-tree / sum register width (signed).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  input bundle valid
- in_ready  output  1  pipeline can accept this cycle
- signed_pp_in  input  45  nine 5-bit {sign,1,mant[2:0]} terms, lane 0 at [44:40], lane 8 at [4:0]; 5'b0 = zero term
- exp_in  input  45  nine 5-bit lane exponents, same lane packing
- exp_max_in  input  5  max of the nine lane exponents
- exp_bias_in  input  5  exponent bias subtracted from the result
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  8  result {sign, exp[3:0], mant[2:0]}
- out_sat  output  1  result saturated (exponent > 15)
- out_flush  output  1  result flushed to zero (exponent < 0)

Behaviour:
- Reset is synchronous and active-high: one clock, rst sampled on posedge clk.
- On rst, all stage valids are 0 and out_valid=0. out_data=8'h00, out_sat=0, out_flush=0, all pipeline data registers 0.
- rst mid-operation discards every in-flight transaction; no output is produced for them.
- Global enable: en = !out_valid || out_ready. in_ready = en.
- A transfer happens when in_valid && in_ready. All stages advance only when en=1.
- Latency is 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- While out_valid && !out_ready: out_data, out_sat, out_flush and all stage registers hold.
- Bubbles (in_valid=0 while en=1) propagate as valid=0.
- Stage A (align):
  - Per lane, sh = exp_max_in - exp_i.
  - mag = {1, mant, GUARD zeros} >> sh; mag = 0 when sh >= 4+GUARD.
  - Term = sign ? -mag : mag, sign-extended to SUM_W.
  - signed_pp == 5'b0 gives term 0 regardless of exp_i.
  - exp_i > exp_max_in is illegal input; behaviour is don't-care.
  - Register the nine terms, exp_max and bias.
- Stage B (sum): signed sum of the nine terms into SUM_W bits (no overflow possible: |sum| <= 9*15*2^GUARD). Register.
- Stage C (normalize):
  - sign = sum < 0; M = |sum|.
  - sum == 0 gives out_data 8'h00, flags 0.
  - p = index of the leading one of M.
  - e = exp_max + p - (GUARD+3) - bias, computed signed 8-bit.
  - mant = M[p-1:p-3], zero-filled below bit 0 when p < 3.
  - e > 15: out_data = {sign, 7'h7F}, out_sat = 1.
  - e < 0: out_data = 8'h00, out_flush = 1.
  - Otherwise out_data = {sign, e[3:0], mant}.
  - A normal result with e=0 and mant=000 encodes as zero; this is accepted as is.
  - Flags apply to the current output only; they are not sticky.

Optional Feature:
- Macro: SD4_ROUND_NEAREST_EN.
- Defined:
  - Stage C rounds mant to nearest-even using the bits below M[p-3].
  - A carry out of mant gives mant=000 and e+1.
  - The saturation check is applied after rounding.
- Undefined: mant is truncated and the lower bits are discarded.
- Latency is 3 cycles either way.

Test Plan:
- Lane 0 = 5'b01010, exp 5; exp_max 5; bias 0; other lanes 0 -> out_data 8'h2A 3 cycles later, flags 0.
- Lanes 0/1 = 5'b01010 / 5'b11010, both exp 5, exp_max 5 -> 8'h00, flags 0. Lanes 0/1 = 5'b01000, both exp 3, exp_max 3 -> 8'h20.
- Single lane 5'b01111 at exp 20, exp_max 20:
  - bias 10 -> 8'h57.
  - bias 0 -> 8'h7F, out_sat=1.
  - same with lane 5'b11111, bias 0 -> 8'hFF, out_sat=1.
  - 5'b01000 at exp 2, exp_max 2, bias 5 -> 8'h00, out_flush=1.
- Lane 0 = 5'b01111 exp 4, lane 1 = 5'b01000 exp 0, exp_max 4, bias 0:
  - without SD4_ROUND_NEAREST_EN -> 8'h27.
  - with SD4_ROUND_NEAREST_EN -> 8'h28 (tie rounds up to even, carry into exponent).
- Stream 5 back-to-back inputs with out_ready=0:
  - out_valid rises after 3 cycles.
  - in_ready falls in the same cycle out_valid rises.
  - out_data holds stable.
  - Release out_ready -> 5 results delivered in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid=0 next cycle, no stale outputs later. First post-reset input appears after exactly 3 cycles.
